sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive data grants after which a pending inst request is forced through.
REQ-002 SHALL have parameter AW, default 32: the address width.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port inst_req, input, 1: fetch read request.
REQ-006 SHALL have port inst_addr, input, AW: fetch address.
REQ-007 SHALL have port inst_addr_ok, output, 1: fetch request accepted this cycle.
REQ-008 SHALL have port inst_data_ok, output, 1: fetch read data valid this cycle.
REQ-009 SHALL have port inst_rdata, output, 32: fetch read data.
REQ-010 SHALL have port data_req, input, 1: load/store request.
REQ-011 SHALL have port data_wr, input, 1: 1 = store, 0 = load.
REQ-012 SHALL have port data_wstrb, input, 4: store byte enables.
REQ-013 SHALL have port data_addr, input, AW: load/store address.
REQ-014 SHALL have port data_wdata, input, 32: store data.
REQ-015 SHALL have port data_addr_ok, output, 1: data request accepted this cycle.
REQ-016 SHALL have port data_data_ok, output, 1: load data valid, or store complete, this cycle.
REQ-017 SHALL have port data_rdata, output, 32: load data.
REQ-018 SHALL have port sram_en, output, 1: shared SRAM port enable.
REQ-019 SHALL have port sram_we, output, 4: shared SRAM byte write enables.
REQ-020 SHALL have port sram_addr, output, AW: shared SRAM address.
REQ-021 SHALL have port sram_wdata, output, 32: shared SRAM write data.
REQ-022 SHALL have port sram_rdata, input, 32: shared SRAM read data, valid 1 cycle after sram_en.

Function
REQ-023 SHALL grant at most one requester per cycle, combinationally.
- addr_ok = grant.
- sram_en = any grant.
REQ-024 SHALL give data priority over inst, except in the forced case.
- Forced case: inst_req=1 and starve counter == STARVE_LIMIT.
- In the forced case inst is granted and data_addr_ok=0.
REQ-025 SHALL maintain the starve counter as follows:
- +1 (saturating at STARVE_LIMIT) on each data grant while inst_req=1.
- Cleared on an inst grant or whenever inst_req=0.
REQ-026 SHALL drive the SRAM port from the granted requester.
- Inst grant: sram_addr=inst_addr, sram_we=0.
- Data grant: sram_addr=data_addr, sram_wdata=data_wdata, sram_we = data_wr ? data_wstrb : 4'b0.
- No grant: sram_en=0 and sram_we=0.
REQ-027 SHALL register the owner of each grant (NONE/INST/DATA).
- In cycle N+1 after a grant in cycle N, the owner's data_ok SHALL be 1 for exactly one cycle.
- A store also returns data_ok.
REQ-028 SHALL drive inst_rdata and data_rdata directly from sram_rdata; they are meaningful only with the matching data_ok.
REQ-029 SHALL accept back-to-back grants every cycle with no bubble.
- Response to grant N and new grant N+1 SHALL coexist in the same cycle.
REQ-030 SHALL never assert inst_data_ok and data_data_ok in the same cycle.
REQ-031 SHALL ignore requester inputs that are not granted; requesters hold req/addr/wdata stable until addr_ok.
REQ-032 SHALL leave data_wstrb without effect on a load (data_wr=0), including data_wstrb=4'b0000.

Reset
REQ-033 SHALL set, on reset: owner=NONE, starve counter=0, inst_data_ok=0, data_data_ok=0.
REQ-034 SHALL force sram_en=0, sram_we=0, inst_addr_ok=0, data_addr_ok=0 while reset=1.
REQ-035 SHALL discard a grant issued in the cycle before reset; no data_ok SHALL follow reset deassertion for it.

Structure
REQ-036 SHALL place the owner encoding constants (OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2) and the STARVE_LIMIT default in the shared CPU macro/package file.
REQ-037 SHALL contain one sub-module, arb_starve_ctr: a saturating counter with inc/clr inputs and a limit_hit output; all other logic stays in the top.

Verification
REQ-038 SHALL cover: inst_req only, addr 0x1C000000 -> inst_addr_ok same cycle; sram_en=1, sram_we=0; next cycle inst_data_ok=1 with inst_rdata = sram_rdata.
REQ-039 SHALL cover: inst_req and data_req together, data load addr 0x100 -> data granted; inst_addr_ok=0; next cycle data_data_ok=1, inst_data_ok=0.
REQ-040 SHALL cover: store data_wstrb=4'b0011, wdata 0xDEADBEEF, addr 0x200 -> sram_we=4'b0011; next cycle data_data_ok=1.
REQ-041 SHALL cover: data_req=1 and inst_req=1 held for 10 cycles, STARVE_LIMIT=4 -> grants D,D,D,D,I,D,D,D,D,I.
REQ-042 SHALL cover: reset asserted in the cycle after an inst grant -> inst_data_ok stays 0; counter=0; first post-reset grant behaves as in REQ-038.
REQ-043 SHALL cover: alternating inst/data grants every cycle for 8 cycles -> 8 responses, each exactly one cycle after its grant; never two data_ok in the same cycle.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: grant owner encoding,
// starvation limit default and a counter-width helper.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int SRAM_DW              = 32;
    localparam int SRAM_BW              = 4;

    // A limit of zero still needs a one-bit counter to compile cleanly.
    function automatic int ctr_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_starve_ctr.sv
// Saturating starvation counter: counts consecutive data grants seen while
// a fetch is waiting and flags when the limit has been reached.
module arb_starve_ctr
    import sram_port_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam int              CW      = ctr_width(LIMIT);
    localparam logic [CW-1:0]   LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over increment so an inst grant always restarts the count.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != LIMIT_V)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign limit_hit = (count_q == LIMIT_V);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a single-ported SRAM: data wins by default,
// a starved fetch is forced through, responses come back one cycle later.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int AW           = 32
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 inst_req,
    input  logic [AW-1:0]        inst_addr,
    output logic                 inst_addr_ok,
    output logic                 inst_data_ok,
    output logic [SRAM_DW-1:0]   inst_rdata,

    input  logic                 data_req,
    input  logic                 data_wr,
    input  logic [SRAM_BW-1:0]   data_wstrb,
    input  logic [AW-1:0]        data_addr,
    input  logic [SRAM_DW-1:0]   data_wdata,
    output logic                 data_addr_ok,
    output logic                 data_data_ok,
    output logic [SRAM_DW-1:0]   data_rdata,

    output logic                 sram_en,
    output logic [SRAM_BW-1:0]   sram_we,
    output logic [AW-1:0]        sram_addr,
    output logic [SRAM_DW-1:0]   sram_wdata,
    input  logic [SRAM_DW-1:0]   sram_rdata
);

    logic   limit_hit;
    logic   forced;
    logic   grant_inst;
    logic   grant_data;
    logic   ctr_inc;
    logic   ctr_clr;
    owner_e owner_q;
    owner_e owner_d;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .reset     (reset),
        .inc       (ctr_inc),
        .clr       (ctr_clr),
        .limit_hit (limit_hit)
    );

    // Reset blocks every grant so nothing reaches the SRAM while it is held.
    always_comb begin
        forced     = inst_req && limit_hit;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!reset) begin
            if (forced) begin
                grant_inst = 1'b1;
            end else if (data_req) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    assign ctr_inc = grant_data && inst_req;
    assign ctr_clr = grant_inst || !inst_req;

    always_comb begin
        owner_d = OWN_NONE;
        if (grant_inst) begin
            owner_d = OWN_INST;
        end else if (grant_data) begin
            owner_d = OWN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        sram_en    = grant_inst || grant_data;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_inst) begin
            sram_addr = inst_addr;
        end else if (grant_data) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            sram_we    = data_wr ? data_wstrb : '0;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // Gating with reset drops a response owed to a grant made just before reset.
    assign inst_data_ok = !reset && (owner_q == OWN_INST);
    assign data_data_ok = !reset && (owner_q == OWN_DATA);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a
// randomized run compared against a behavioural arbitration model.
module tb_sram_port_arbiter;

    localparam int LIMIT = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [31:0]   inst_rdata;
    logic          data_req;
    logic          data_wr;
    logic [3:0]    data_wstrb;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending response owner (0 none, 1 inst, 2 data) and
    // the number of data grants a waiting fetch has sat through.
    int m_pend   = 0;
    int m_starve = 0;

    sram_port_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .AW           (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    // Who should win this cycle, from the arbitration rules alone.
    function automatic int exp_winner();
        if (reset) return 0;
        if (inst_req && m_starve >= LIMIT) return 1;
        if (data_req) return 2;
        if (inst_req) return 1;
        return 0;
    endfunction

    function automatic int obs_grant();
        return (inst_addr_ok ? 1 : 0) + (data_addr_ok ? 2 : 0);
    endfunction

    // Cross the rising edge, update the model, then leave room to drive.
    task automatic advance();
        int w;
        @(posedge clk);
        w = exp_winner();
        if (reset) begin
            m_pend   = 0;
            m_starve = 0;
        end else begin
            m_pend = w;
            if (!inst_req || w == 1) m_starve = 0;
            else if (w == 2 && m_starve < LIMIT) m_starve = m_starve + 1;
        end
        #1;
    endtask

    task automatic drive_idle();
        inst_req   = 1'b0;
        inst_addr  = $urandom;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'h0;
        data_addr  = $urandom;
        data_wdata = $urandom;
        sram_rdata = $urandom;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        drive_idle();
        inst_req = 1'b1;
        data_req = 1'b1;
        data_wr  = 1'b1;
        data_wstrb = 4'hF;
        @(negedge clk);
        n_cmp++;
        if ({inst_addr_ok, data_addr_ok, sram_en, sram_we} !== 7'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000000",
                     {inst_addr_ok, data_addr_ok, sram_en, sram_we});
        end
        advance();
        @(negedge clk);
        n_cmp++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL reset_data_ok: got %b expected 00", {inst_data_ok, data_data_ok});
        end
        advance();
        reset = 1'b0;
        drive_idle();
        advance();
    endtask

    task automatic test_inst_only();
        logic [31:0] rd;
        drive_idle();
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        @(negedge clk);
        n_cmp++;
        if ({inst_addr_ok, data_addr_ok, sram_en, sram_we} !== 7'b1010000) begin
            n_bad++;
            $display("[TB] FAIL inst_grant: got %b expected 1010000",
                     {inst_addr_ok, data_addr_ok, sram_en, sram_we});
        end
        n_cmp++;
        if (sram_addr !== 32'h1C00_0000) begin
            n_bad++;
            $display("[TB] FAIL inst_sram_addr: got %h expected 1c000000", sram_addr);
        end
        advance();
        drive_idle();
        rd = sram_rdata;
        @(negedge clk);
        n_cmp++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, rd}) begin
            n_bad++;
            $display("[TB] FAIL inst_response: got %b/%h expected 10/%h",
                     {inst_data_ok, data_data_ok}, inst_rdata, rd);
        end
        advance();
    endtask

    task automatic test_data_priority();
        logic [31:0] rd;
        drive_idle();
        inst_req   = 1'b1;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_wstrb = 4'($urandom);
        data_addr  = 32'h0000_0100;
        @(negedge clk);
        n_cmp++;
        if ({inst_addr_ok, data_addr_ok, sram_en, sram_we} !== 7'b0110000) begin
            n_bad++;
            $display("[TB] FAIL data_priority_grant: got %b expected 0110000",
                     {inst_addr_ok, data_addr_ok, sram_en, sram_we});
        end
        n_cmp++;
        if (sram_addr !== 32'h0000_0100) begin
            n_bad++;
            $display("[TB] FAIL data_sram_addr: got %h expected 00000100", sram_addr);
        end
        advance();
        drive_idle();
        rd = sram_rdata;
        @(negedge clk);
        n_cmp++;
        if ({inst_data_ok, data_data_ok, data_rdata} !== {2'b01, rd}) begin
            n_bad++;
            $display("[TB] FAIL load_response: got %b/%h expected 01/%h",
                     {inst_data_ok, data_data_ok}, data_rdata, rd);
        end
        advance();
    endtask

    task automatic test_store();
        drive_idle();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_wdata = 32'hDEAD_BEEF;
        data_addr  = 32'h0000_0200;
        @(negedge clk);
        n_cmp++;
        if ({data_addr_ok, sram_en, sram_we, sram_addr, sram_wdata} !==
            {2'b11, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("[TB] FAIL store_port: got ok=%b en=%b we=%b addr=%h wdata=%h expected 1 1 0011 00000200 deadbeef",
                     data_addr_ok, sram_en, sram_we, sram_addr, sram_wdata);
        end
        advance();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL store_response: got %b expected 01", {inst_data_ok, data_data_ok});
        end
        advance();
    endtask

    task automatic test_starvation();
        int exp_seq [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        int g;
        for (int i = 0; i < 10; i++) begin
            drive_idle();
            inst_req = 1'b1;
            data_req = 1'b1;
            @(negedge clk);
            g = obs_grant();
            n_cmp++;
            if (g !== exp_seq[i]) begin
                n_bad++;
                $display("[TB] FAIL starve_grant_%0d: got %0d expected %0d", i, g, exp_seq[i]);
            end
            advance();
        end
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL starve_last_response: got %b expected 10", {inst_data_ok, data_data_ok});
        end
        advance();
    endtask

    task automatic test_reset_mid();
        int exp_seq [5] = '{2, 2, 2, 2, 1};
        int g;
        drive_idle();
        inst_req = 1'b1;
        advance();
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (inst_data_ok !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_drops_response: got %b expected 0", inst_data_ok);
        end
        advance();
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL post_reset_no_response: got %b expected 00", {inst_data_ok, data_data_ok});
        end
        advance();
        test_inst_only();
        // Build up some starvation, reset, and expect a full fresh count.
        for (int i = 0; i < 2; i++) begin
            drive_idle();
            inst_req = 1'b1;
            data_req = 1'b1;
            advance();
        end
        drive_idle();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            inst_req = 1'b1;
            data_req = 1'b1;
            @(negedge clk);
            g = obs_grant();
            n_cmp++;
            if (g !== exp_seq[i]) begin
                n_bad++;
                $display("[TB] FAIL post_reset_count_%0d: got %0d expected %0d", i, g, exp_seq[i]);
            end
            advance();
        end
        drive_idle();
        advance();
    endtask

    task automatic test_back_to_back();
        int n_resp = 0;
        int g;
        for (int i = 0; i <= 8; i++) begin
            drive_idle();
            if (i < 8) begin
                inst_req = (i % 2 == 0);
                data_req = (i % 2 == 1);
                data_wr  = 1'($urandom);
                data_wstrb = 4'($urandom);
            end
            @(negedge clk);
            if (i < 8) begin
                g = obs_grant();
                n_cmp++;
                if (g !== ((i % 2 == 0) ? 1 : 2)) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_grant_%0d: got %0d expected %0d", i, g, (i % 2 == 0) ? 1 : 2);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if ({inst_data_ok, data_data_ok} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_response_%0d: got %b expected %b", i - 1,
                             {inst_data_ok, data_data_ok}, (((i - 1) % 2 == 0) ? 2'b10 : 2'b01));
                end
            end
            n_resp += int'(inst_data_ok) + int'(data_data_ok);
            advance();
        end
        n_cmp++;
        if (n_resp !== 8) begin
            n_bad++;
            $display("[TB] FAIL b2b_response_count: got %0d expected 8", n_resp);
        end
    endtask

    task automatic test_random();
        int w;
        logic [3:0]    exp_we;
        logic [AW-1:0] exp_addr;
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 24) == 0);
            inst_req   = ($urandom_range(0, 3) != 0);
            data_req   = ($urandom_range(0, 3) != 0);
            inst_addr  = $urandom;
            data_addr  = $urandom;
            data_wr    = 1'($urandom);
            data_wstrb = 4'($urandom);
            data_wdata = $urandom;
            sram_rdata = $urandom;
            @(negedge clk);
            w        = exp_winner();
            exp_we   = (w == 2 && data_wr) ? data_wstrb : 4'h0;
            exp_addr = (w == 1) ? inst_addr : data_addr;
            n_cmp++;
            if ({inst_addr_ok, data_addr_ok, sram_en, sram_we} !== {w == 1, w == 2, w != 0, exp_we}) begin
                n_bad++;
                $display("[TB] FAIL rand_grant_%0d: got %b expected %b", i,
                         {inst_addr_ok, data_addr_ok, sram_en, sram_we}, {w == 1, w == 2, w != 0, exp_we});
            end
            if (w != 0) begin
                n_cmp++;
                if (sram_addr !== exp_addr) begin
                    n_bad++;
                    $display("[TB] FAIL rand_addr_%0d: got %h expected %h", i, sram_addr, exp_addr);
                end
            end
            if (w == 2) begin
                n_cmp++;
                if (sram_wdata !== data_wdata) begin
                    n_bad++;
                    $display("[TB] FAIL rand_wdata_%0d: got %h expected %h", i, sram_wdata, data_wdata);
                end
            end
            n_cmp++;
            if ({inst_data_ok, data_data_ok} !== {!reset && m_pend == 1, !reset && m_pend == 2}) begin
                n_bad++;
                $display("[TB] FAIL rand_data_ok_%0d: got %b expected %b", i,
                         {inst_data_ok, data_data_ok}, {!reset && m_pend == 1, !reset && m_pend == 2});
            end
            if (!reset && m_pend != 0) begin
                n_cmp++;
                if (((m_pend == 1) ? inst_rdata : data_rdata) !== sram_rdata) begin
                    n_bad++;
                    $display("[TB] FAIL rand_rdata_%0d: got %h expected %h", i,
                             (m_pend == 1) ? inst_rdata : data_rdata, sram_rdata);
                end
            end
            advance();
        end
        reset = 1'b0;
        drive_idle();
        advance();
    endtask

    initial begin
        $display("[TB] starting sram_port_arbiter bench");
        test_reset();
        test_inst_only();
        test_data_priority();
        test_store();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
